multicycle_controller: RTL

//  Control FSM that sequences the RV32I datapath over multiple cycles: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.

---
 rtl/multicycle_controller_pkg.sv | 38 +++
 rtl/multicycle_controller_if.sv | 26 ++
 rtl/multicycle_controller_wait_timer.sv | 23 ++
 rtl/multicycle_controller.sv | 124 ++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
// Optional feature macro: MC_HALT_EN (SYSTEM opcode parks the core in HALT).
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_ERROR     = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_FETCH_TO = 2'b01;
  localparam logic [1:0] ERR_DATA_TO  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Opcodes that complete without a data-memory access
  function automatic logic is_reg_class(input logic [6:0] op);
    return (op == OP_OP)  || (op == OP_OPIMM) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
           (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Handshake/strobe bundle between the control FSM and datapath/memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       fetch_ready;
  logic       dmem_ready;
  logic       fetch_req;
  logic       ir_write;
  logic       dmem_req;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       reg_write_en;
  logic       pc_write;

  modport master (
    input  opcode, fetch_ready, dmem_ready,
    output fetch_req, ir_write, dmem_req, mem_read_en, mem_write_en,
           reg_write_en, pc_write
  );

  modport slave (
    output opcode, fetch_ready, dmem_ready,
    input  fetch_req, ir_write, dmem_req, mem_read_en, mem_write_en,
           reg_write_en, pc_write
  );
endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// Bus-wait watchdog shared by FETCH and MEM. expire fires in the
// WAIT_MAX-th consecutive enabled cycle; clear has priority.
module wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  // Count consecutive wait cycles; saturate at LAST (FSM leaves on expire)
  always_ff @(posedge clk) begin
    if (clear)                  count <= '0;
    else if (enable && !expire) count <= count + 1'b1;
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// memory handshakes, datapath strobes, retired count and trap capture.
// Optional feature macro: MC_HALT_EN (SYSTEM -> HALT instead of NOP).
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX  = 16,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_controller_if.master bus,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 error,
  output logic [1:0]           err_cause,
  output logic                 halted
);
  state_t st;
  logic   is_load, is_store, is_system, goes_wb, goes_halt;
  logic   wait_en, wait_clr, wait_exp;

  assign is_load   = (bus.opcode == OP_LOAD);
  assign is_store  = (bus.opcode == OP_STORE);
  assign is_system = (bus.opcode == OP_SYSTEM);

`ifdef MC_HALT_EN
  assign goes_wb   = is_reg_class(bus.opcode);
  assign goes_halt = is_system;
  assign halted    = (st == ST_HALT);
`else
  assign goes_wb   = is_reg_class(bus.opcode) || is_system;
  assign goes_halt = 1'b0;
  assign halted    = 1'b0;
`endif

  assign state = st;

  // Timer runs only while stalled on a handshake; any other cycle rearms it
  assign wait_en  = !reset && (((st == ST_FETCH) && !bus.fetch_ready) ||
                               ((st == ST_MEM)   && !bus.dmem_ready));
  assign wait_clr = !wait_en;

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk    (clk),
    .clear  (wait_clr),
    .enable (wait_en),
    .expire (wait_exp)
  );

  // State sequencing, retired-instruction count and sticky trap capture
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_FETCH;
      instret   <= '0;
      error     <= 1'b0;
      err_cause <= ERR_NONE;
    end else begin
      case (st)
        ST_FETCH: begin
          if (bus.fetch_ready) st <= ST_DECODE;
          else if (wait_exp) begin
            st        <= ST_ERROR;
            error     <= 1'b1;
            err_cause <= ERR_FETCH_TO;
          end
        end
        ST_DECODE:  st <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (is_load || is_store) st <= ST_MEM;
          else if (goes_wb)        st <= ST_WRITEBACK;
          else if (goes_halt)      st <= ST_HALT;
          else begin
            st        <= ST_ERROR;
            error     <= 1'b1;
            err_cause <= ERR_ILLEGAL;
          end
        end
        ST_MEM: begin
          if (bus.dmem_ready) st <= ST_WRITEBACK;
          else if (wait_exp) begin
            st        <= ST_ERROR;
            error     <= 1'b1;
            err_cause <= ERR_DATA_TO;
          end
        end
        ST_WRITEBACK: begin
          instret <= instret + 1'b1;
          st      <= ST_FETCH;
        end
        default: st <= st;  // ERROR and HALT park until reset
      endcase
    end
  end

  // Strobe decode; ir_write is Mealy on fetch_ready, all forced low in reset
  always_comb begin
    bus.fetch_req    = 1'b0;
    bus.ir_write     = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.pc_write     = 1'b0;
    if (!reset) begin
      case (st)
        ST_FETCH: begin
          bus.fetch_req = 1'b1;
          bus.ir_write  = bus.fetch_ready;
        end
        ST_MEM: begin
          bus.dmem_req     = 1'b1;
          bus.mem_read_en  = is_load;
          bus.mem_write_en = is_store;
        end
        ST_WRITEBACK: begin
          bus.pc_write     = 1'b1;
          bus.reg_write_en = !(is_store || (bus.opcode == OP_BRANCH) || is_system);
        end
        default: ;
      endcase
    end
  end
endmodule
